// File: rtl/dds_pkg.sv
// Shared constants, state encoding and LFSR step for the DDS phase generator.
package dds_pkg;

    localparam int DDS_ACC_WIDTH  = 32;
    localparam int DDS_ADDR_WIDTH = 8;

    typedef enum logic [0:0] {
        DDS_IDLE = 1'b0,
        DDS_RUN  = 1'b1
    } dds_state_t;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
    localparam logic [15:0] DDS_LFSR_SEED = 16'hACE1;
    localparam logic [15:0] DDS_LFSR_POLY = 16'hB400;

    function automatic logic [15:0] dds_lfsr_next(input logic [15:0] state);
        logic [15:0] nxt;
        nxt = {1'b0, state[15:1]};
        if (state[0]) begin
            nxt = nxt ^ DDS_LFSR_POLY;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/dds_phase_gen_tick.sv
// Sample-rate divider: pulses tick once every TICK_DIV cycles while not cleared.
module sample_tick_gen
    import dds_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Tick is combinational so the accumulator updates on the terminal-count edge.
    always_comb begin
        tick = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Divider counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dds_phase_gen.sv
// NCO phase accumulator driving the sine ROM address with deferred FTW updates.
// Optional address dither enabled by defining DDS_PHASE_DITHER_EN.
module dds_phase_gen
    import dds_pkg::*;
#(
    parameter int ACC_WIDTH  = DDS_ACC_WIDTH,
    parameter int ADDR_WIDTH = DDS_ADDR_WIDTH,
    parameter int TICK_DIV   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [ACC_WIDTH-1:0]  ftw_in,
    input  logic                  ftw_load,
    input  logic [ADDR_WIDTH-1:0] poff_in,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  addr_valid,
    output logic                  wrap,
    output logic                  ftw_busy
);

    dds_state_t            state_q, state_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [ACC_WIDTH-1:0]  ftw_act_q, ftw_act_d;
    logic [ACC_WIDTH-1:0]  ftw_pend_q, ftw_pend_d;
    logic                  pend_q, pend_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  addr_valid_q, addr_valid_d;
    logic                  wrap_q, wrap_d;

    logic                  tick_s;
    logic                  clear_s;
    logic [ACC_WIDTH:0]    acc_sum_s;
    logic [ACC_WIDTH-1:0]  acc_next_s;
    logic                  carry_s;
    logic [ACC_WIDTH-1:0]  addr_src_s;
    logic                  apply_s;

    assign clear_s = (state_q != DDS_RUN) || !en;

    sample_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear_s),
        .tick  (tick_s)
    );

    assign acc_sum_s  = {1'b0, acc_q} + {1'b0, ftw_act_q};
    assign acc_next_s = acc_sum_s[ACC_WIDTH-1:0];
    assign carry_s    = acc_sum_s[ACC_WIDTH];

`ifdef DDS_PHASE_DITHER_EN
    localparam int DITH_W = ACC_WIDTH - ADDR_WIDTH;

    logic [15:0]          lfsr_q, lfsr_d;
    logic [ACC_WIDTH-1:0] dith_s;

    // Low LFSR bits below the address LSB; dither only perturbs addr, never acc.
    always_comb begin
        dith_s = '0;
        for (int i = 0; i < DITH_W && i < 16; i++) begin
            dith_s[i] = lfsr_q[i];
        end
        if (tick_s) begin
            lfsr_d = dds_lfsr_next(lfsr_q);
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    assign addr_src_s = acc_next_s + dith_s;

    // Dither LFSR register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= DDS_LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign addr_src_s = acc_next_s;
`endif

    // Run/idle FSM with accumulator and address update on sample ticks.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        addr_d       = addr_q;
        addr_valid_d = 1'b0;
        wrap_d       = 1'b0;
        case (state_q)
            DDS_IDLE: begin
                acc_d = '0;
                if (en) begin
                    state_d = DDS_RUN;
                end else begin
                    state_d = DDS_IDLE;
                end
            end
            DDS_RUN: begin
                if (!en) begin
                    state_d = DDS_IDLE;
                    acc_d   = '0;
                end else if (tick_s) begin
                    acc_d        = acc_next_s;
                    addr_d       = addr_src_s[ACC_WIDTH-1 -: ADDR_WIDTH] + poff_in;
                    addr_valid_d = 1'b1;
                    wrap_d       = carry_s;
                end else begin
                    acc_d = acc_q;
                end
            end
            default: begin
                state_d = DDS_IDLE;
                acc_d   = '0;
            end
        endcase
    end

    // A fresh load always wins over applying the older pending word.
    assign apply_s = pend_q && !ftw_load &&
                     ((state_q == DDS_IDLE) || (tick_s && carry_s));

    // FTW shadow register: capture on load, transfer to active on idle or wrap.
    always_comb begin
        ftw_act_d  = ftw_act_q;
        ftw_pend_d = ftw_pend_q;
        pend_d     = pend_q;
        if (apply_s) begin
            ftw_act_d = ftw_pend_q;
            pend_d    = 1'b0;
        end else begin
            ftw_act_d = ftw_act_q;
        end
        if (ftw_load) begin
            ftw_pend_d = ftw_in;
            pend_d     = 1'b1;
        end else begin
            ftw_pend_d = ftw_pend_q;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= DDS_IDLE;
            acc_q        <= '0;
            ftw_act_q    <= '0;
            ftw_pend_q   <= '0;
            pend_q       <= 1'b0;
            addr_q       <= '0;
            addr_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            ftw_act_q    <= ftw_act_d;
            ftw_pend_q   <= ftw_pend_d;
            pend_q       <= pend_d;
            addr_q       <= addr_d;
            addr_valid_q <= addr_valid_d;
            wrap_q       <= wrap_d;
        end
    end

    assign addr       = addr_q;
    assign addr_valid = addr_valid_q;
    assign wrap       = wrap_q;
    assign ftw_busy   = pend_q;

endmodule

// File: tb/tb_dds_phase_gen.sv
// Directed self-checking bench for dds_phase_gen (TICK_DIV=1 and TICK_DIV=4 instances).
module tb_dds_phase_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, ftw_load, en4, load4;
    logic [31:0] ftw_in, ftw4;
    logic [7:0]  poff_in, poff4;
    logic [7:0]  addr, addr4;
    logic        addr_valid, wrap, ftw_busy;
    logic        valid4, wrap4, busy4;
    int          checks = 0;
    int          passes = 0;

    always #5 clk = ~clk;

    dds_phase_gen #(.ACC_WIDTH(32), .ADDR_WIDTH(8), .TICK_DIV(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ftw_in(ftw_in), .ftw_load(ftw_load),
        .poff_in(poff_in), .addr(addr), .addr_valid(addr_valid), .wrap(wrap),
        .ftw_busy(ftw_busy));

    dds_phase_gen #(.ACC_WIDTH(32), .ADDR_WIDTH(8), .TICK_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en4), .ftw_in(ftw4), .ftw_load(load4),
        .poff_in(poff4), .addr(addr4), .addr_valid(valid4), .wrap(wrap4),
        .ftw_busy(busy4));

    // With dither the address may sit one step above the plain truncation.
    function automatic bit addr_ok(input logic [7:0] act, input logic [7:0] exp);
`ifdef DDS_PHASE_DITHER_EN
        logic [7:0] exp_p1;
        exp_p1 = exp + 8'd1;
        return (act === exp) || (act === exp_p1);
`else
        return act === exp;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (addr !== 8'h00) $display("FAIL reset_addr got=%0h exp=0", addr); else passes++;
        checks++; if (addr_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", addr_valid); else passes++;
        checks++; if (wrap !== 1'b0) $display("FAIL reset_wrap got=%0b exp=0", wrap); else passes++;
        checks++; if (ftw_busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", ftw_busy); else passes++;
        checks++; if ({addr4, valid4, wrap4, busy4} !== 11'h0) $display("FAIL reset_div4 got=%0h exp=0", {addr4, valid4, wrap4, busy4}); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sweep();
        ftw_in = 32'h0100_0000; ftw_load = 1'b1;
        step();
        ftw_load = 1'b0;
        checks++; if (ftw_busy !== 1'b1) $display("FAIL idle_load_busy got=%0b exp=1", ftw_busy); else passes++;
        step();
        checks++; if (ftw_busy !== 1'b0) $display("FAIL idle_apply_busy got=%0b exp=0", ftw_busy); else passes++;
        en = 1'b1;
        step();
        checks++; if (addr_valid !== 1'b0) $display("FAIL entry_valid got=%0b exp=0", addr_valid); else passes++;
        for (int k = 1; k <= 256; k++) begin
            step();
            checks++;
            if (!addr_ok(addr, 8'(k)) || addr_valid !== 1'b1 || wrap !== (k == 256))
                $display("FAIL sweep k=%0d got addr=%0h v=%0b w=%0b exp addr=%0h v=1 w=%0b",
                         k, addr, addr_valid, wrap, 8'(k), (k == 256));
            else passes++;
`ifdef DDS_PHASE_DITHER_EN
            if (k == 1) begin
                checks++;
                if (dut.lfsr_q !== 16'hE270) $display("FAIL lfsr_first got=%0h exp=e270", dut.lfsr_q);
                else passes++;
            end
`endif
        end
    endtask

    task automatic test_ftw_change();
        for (int k = 1; k <= 16; k++) begin
            step();
            checks++; if (!addr_ok(addr, 8'(k)) || wrap !== 1'b0) $display("FAIL pre_change k=%0d got=%0h exp=%0h", k, addr, 8'(k)); else passes++;
        end
        ftw_in = 32'h0200_0000; ftw_load = 1'b1;
        step();
        ftw_load = 1'b0;
        checks++; if (!addr_ok(addr, 8'h11) || ftw_busy !== 1'b1) $display("FAIL change_load got addr=%0h busy=%0b exp addr=11 busy=1", addr, ftw_busy); else passes++;
        for (int k = 8'h12; k <= 8'hFF; k++) begin
            step();
            checks++; if (!addr_ok(addr, 8'(k)) || wrap !== 1'b0 || ftw_busy !== 1'b1) $display("FAIL change_hold k=%0h got addr=%0h busy=%0b", k, addr, ftw_busy); else passes++;
        end
        step();
        checks++; if (!addr_ok(addr, 8'h00) || wrap !== 1'b1 || ftw_busy !== 1'b0) $display("FAIL change_wrap got addr=%0h w=%0b busy=%0b exp 0/1/0", addr, wrap, ftw_busy); else passes++;
        for (int j = 1; j <= 4; j++) begin
            step();
            checks++; if (!addr_ok(addr, 8'(2 * j)) || wrap !== 1'b0) $display("FAIL change_step2 j=%0d got=%0h exp=%0h", j, addr, 8'(2 * j)); else passes++;
        end
    endtask

    task automatic test_load_at_wrap();
        ftw_in = 32'h0400_0000; ftw_load = 1'b1;
        step();
        ftw_load = 1'b0;
        checks++; if (!addr_ok(addr, 8'h0A) || ftw_busy !== 1'b1) $display("FAIL law_load got addr=%0h busy=%0b exp 0a/1", addr, ftw_busy); else passes++;
        for (int v = 8'h0C; v <= 8'hFE; v += 2) begin
            step();
            checks++; if (!addr_ok(addr, 8'(v)) || wrap !== 1'b0) $display("FAIL law_run1 got=%0h exp=%0h", addr, 8'(v)); else passes++;
        end
        ftw_in = 32'h0100_0000; ftw_load = 1'b1;
        step();
        ftw_load = 1'b0;
        checks++; if (!addr_ok(addr, 8'h00) || wrap !== 1'b1 || ftw_busy !== 1'b1) $display("FAIL law_coincide got addr=%0h w=%0b busy=%0b exp 0/1/1", addr, wrap, ftw_busy); else passes++;
        for (int v = 8'h02; v <= 8'hFE; v += 2) begin
            step();
            checks++; if (!addr_ok(addr, 8'(v)) || wrap !== 1'b0) $display("FAIL law_run2 got=%0h exp=%0h", addr, 8'(v)); else passes++;
        end
        step();
        checks++; if (!addr_ok(addr, 8'h00) || wrap !== 1'b1 || ftw_busy !== 1'b0) $display("FAIL law_wrap2 got addr=%0h w=%0b busy=%0b exp 0/1/0", addr, wrap, ftw_busy); else passes++;
        step();
        checks++; if (!addr_ok(addr, 8'h01)) $display("FAIL law_newstep got=%0h exp=01", addr); else passes++;
    endtask

    task automatic test_enable();
        en = 1'b0;
        step();
        checks++; if (addr_valid !== 1'b0 || wrap !== 1'b0 || !addr_ok(addr, 8'h01)) $display("FAIL en_drop got addr=%0h v=%0b exp addr=01 v=0", addr, addr_valid); else passes++;
        step();
        checks++; if (addr_valid !== 1'b0 || !addr_ok(addr, 8'h01)) $display("FAIL en_hold got addr=%0h v=%0b exp addr=01 v=0", addr, addr_valid); else passes++;
        en = 1'b1;
        step();
        checks++; if (addr_valid !== 1'b0) $display("FAIL en_entry got v=%0b exp 0", addr_valid); else passes++;
        step();
        checks++; if (!addr_ok(addr, 8'h01) || addr_valid !== 1'b1) $display("FAIL en_restart got addr=%0h v=%0b exp 01/1", addr, addr_valid); else passes++;
        step();
        checks++; if (!addr_ok(addr, 8'h02)) $display("FAIL en_restart2 got=%0h exp=02", addr); else passes++;
    endtask

    task automatic test_poff();
        en = 1'b0;
        step();
        poff_in = 8'h40; en = 1'b1;
        step();
        for (int k = 1; k <= 256; k++) begin
            step();
            checks++;
            if (!addr_ok(addr, 8'(k + 8'h40)) || addr_valid !== 1'b1 || wrap !== (k == 256))
                $display("FAIL poff k=%0d got addr=%0h w=%0b exp addr=%0h w=%0b", k, addr, wrap, 8'(k + 8'h40), (k == 256));
            else passes++;
        end
    endtask

    task automatic test_reset_midrun();
        poff_in = 8'h00;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({addr, addr_valid, wrap, ftw_busy} !== 11'h0) $display("FAIL async_reset got=%0h exp=0", {addr, addr_valid, wrap, ftw_busy}); else passes++;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        poff_in = 8'h05;
        step();
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++; if (!addr_ok(addr, 8'h05) || addr_valid !== 1'b1 || wrap !== 1'b0) $display("FAIL zero_ftw k=%0d got addr=%0h v=%0b w=%0b exp 05/1/0", k, addr, addr_valid, wrap); else passes++;
        end
        en = 1'b0; poff_in = 8'h00;
        step();
        ftw_in = 32'h0100_0000; ftw_load = 1'b1;
        step();
        ftw_load = 1'b0;
        step();
        checks++; if (ftw_busy !== 1'b0) $display("FAIL rst_reload_busy got=%0b exp=0", ftw_busy); else passes++;
        en = 1'b1;
        step();
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++; if (!addr_ok(addr, 8'(k)) || addr_valid !== 1'b1) $display("FAIL rst_restart k=%0d got=%0h exp=%0h", k, addr, 8'(k)); else passes++;
        end
    endtask

    task automatic test_tick_div();
        logic [7:0] ea;
        ea = 8'h00;
        ftw4 = 32'h0080_0000; load4 = 1'b1;
        step();
        load4 = 1'b0;
        step();
        en4 = 1'b1;
        step();
        for (int s = 1; s <= 16; s++) begin
            step();
            if (s % 4 == 0) ea = 8'((s / 4) / 2) + poff4;
            checks++;
            if (valid4 !== (s % 4 == 0) || !addr_ok(addr4, ea) || wrap4 !== 1'b0)
                $display("FAIL div4 s=%0d got addr=%0h v=%0b exp addr=%0h v=%0b", s, addr4, valid4, ea, (s % 4 == 0));
            else passes++;
            if (s == 6) poff4 = 8'h10;
        end
    endtask

    initial begin
        en = 1'b0; ftw_load = 1'b0; ftw_in = 32'h0; poff_in = 8'h00;
        en4 = 1'b0; load4 = 1'b0; ftw4 = 32'h0; poff4 = 8'h00;
        test_reset();
        test_sweep();
        test_ftw_change();
        test_load_at_wrap();
        test_enable();
        test_poff();
        test_reset_midrun();
        test_tick_div();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
